// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter -- iterative multiply/divide unit with architectural HI/LO.
//
// Serves MULT/MULTU/DIV/DIVU (op = 00/01/10/11) and MTHI/MTLO from the EX
// stage. An operation is launched with start while idle, runs for WIDTH
// iterations (shift-add multiply or restoring divide), then writes HI/LO and
// pulses done. busy stays high from the launch edge until the write edge.
//
// Optional build macro: MDU_FAST_MUL_EN
//   defined   -> MULT/MULTU use a combinational product and finish one edge
//                after launch; division stays iterative.
//   undefined -> multiply iterates with the same latency as division.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start, op    launch request and operation select (sampled when idle)
//   num1, num2   multiplicand/dividend and multiplier/divisor
//   cancel       abort the in-flight operation, no result and no done
//   wr_hi, wr_lo MTHI/MTLO write strobes, data on wdata
//   busy         operation in flight
//   done         one-cycle pulse, hi/lo already hold the result
//   div_zero     one-cycle pulse with done for a divide by zero
//   hi, lo       architectural HI/LO registers
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operation context captured at launch.
    logic               r_is_div;
    logic               r_dz;
    logic               r_sign1;
    logic               r_sign2;
    logic [CNT_W-1:0]   r_cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   low half holds dividend bits shifting out / quotient bits in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_b;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    // ------------------------------------------------------------------------
    // Launch-side decode
    // ------------------------------------------------------------------------
    logic               w_launch;
    logic               w_signed;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_div_by_zero;
    logic               w_fast_mul;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_launch      = (r_state == S_IDLE) && start && !cancel;
    assign w_signed      = ~op[0];
    assign w_neg1        = w_signed & num1[WIDTH-1];
    assign w_neg2        = w_signed & num2[WIDTH-1];
    assign w_mag1        = w_neg1 ? -num1 : num1;
    assign w_mag2        = w_neg2 ? -num2 : num2;
    assign w_div_by_zero = op[1] && (num2 == '0);

`ifdef MDU_FAST_MUL_EN
    // Sign- or zero-extend to 2*WIDTH so the low 2*WIDTH bits of a plain
    // product are the correct signed/unsigned result.
    assign w_fast_mul  = ~op[1];
    assign w_fast_prod = op[0]
                       ? ({{WIDTH{1'b0}}, num1} * {{WIDTH{1'b0}}, num2})
                       : ({{WIDTH{num1[WIDTH-1]}}, num1} * {{WIDTH{num2[WIDTH-1]}}, num2});
`else
    assign w_fast_mul  = 1'b0;
    assign w_fast_prod = '0;
`endif

    // ------------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;

    // Add the multiplicand when the current multiplier bit is set, then shift
    // the whole accumulator right, carry included.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Partial remainder is WIDTH+1 bits after bringing down the next dividend
    // bit; bit WIDTH of the difference is the borrow (remainder < divisor).
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_ge    = ~w_diff[WIDTH];

    // ------------------------------------------------------------------------
    // Signed fix-up of the magnitude results
    // ------------------------------------------------------------------------
    logic               w_res_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_res_neg = r_sign1 ^ r_sign2;
    assign w_prod    = w_res_neg ? -r_acc : r_acc;
    assign w_quo     = w_res_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    // Remainder follows the dividend's sign. MIN / -1 needs no special case:
    // the magnitude quotient 2^(WIDTH-1) negates back to MIN, remainder 0.
    assign w_rem_fix = r_sign1 ? -r_rem : r_rem;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: the next-state default is assigned first so no path through this
    // block leaves w_next unassigned, which would infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (w_div_by_zero || w_fast_mul) w_next = S_FIN;
                    else                             w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (cancel)                    w_next = S_IDLE;
                else if (r_cnt == CNT_W'(1))   w_next = S_FIN;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // NOTE: working registers carry no reset; they are always loaded at launch
    // before being read, so resetting them would only add logic.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_is_div <= op[1];
            r_dz     <= w_div_by_zero;
            r_cnt    <= CNT_W'(WIDTH);
            r_rem    <= '0;
            if (w_fast_mul) begin
                r_acc   <= w_fast_prod;
                r_b     <= w_mag1;
                r_sign1 <= 1'b0;
                r_sign2 <= 1'b0;
            end else if (op[1]) begin
                r_acc   <= {{WIDTH{1'b0}}, w_mag1};
                r_b     <= w_mag2;
                r_sign1 <= w_neg1;
                r_sign2 <= w_neg2;
            end else begin
                r_acc   <= {{WIDTH{1'b0}}, w_mag2};
                r_b     <= w_mag1;
                r_sign1 <= w_neg1;
                r_sign2 <= w_neg2;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_is_div) begin
                r_rem            <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_ge};
            end else begin
                r_acc <= w_mul_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Architectural registers and status pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            if (wr_hi) r_hi <= wdata;
            if (wr_lo) r_lo <= wdata;
            // NOTE: this result write comes after the MTHI/MTLO writes, so on
            // a same-edge collision the last non-blocking assignment (the
            // result) is the one that takes effect.
            if (r_state == S_FIN && !cancel) begin
                r_done <= 1'b1;
                if (r_dz) begin
                    r_div_zero <= 1'b1;
                end else if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo;
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// ============================================================================
// tb_mdu_iter -- self-checking bench for mdu_iter at WIDTH = 32.
// Fixed vectors from a table, hand-written multi-cycle sequences (busy/done
// timing, divide by zero, cancel, reset, HI/LO write collisions, back-to-back)
// and randomized operations checked against a 64-bit arithmetic model.
// ============================================================================
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         cancel;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_pass  = 0;
    int           n_total = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .num1     (num1),
        .num2     (num2),
        .cancel   (cancel),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
        if (o[1] && b == '0) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!o[1]) return 1;
`endif
        return W + 1;
    endfunction

    // Reference: plain 64-bit arithmetic. SV integer division truncates
    // toward zero and % takes the dividend's sign, matching the ISA rules.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
        longint          sa, sb, p, q, r;
        longint unsigned up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        eh  = m_hi;
        el  = m_lo;
        edz = 1'b0;
        case (o)
            2'b00: begin p = sa * sb; {eh, el} = p; end
            2'b01: begin up = {32'h0, a} * {32'h0, b}; {eh, el} = up; end
            2'b10: begin
                if (b == '0) edz = 1'b1;
                else begin q = sa / sb; r = sa % sb; el = q[W-1:0]; eh = r[W-1:0]; end
            end
            default: begin
                if (b == '0) edz = 1'b1;
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endtask

    // Present an op for one edge (E0), then scramble the inputs so any
    // late sampling of num1/num2/op would corrupt the result.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        num1  = a;
        num2  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        op    = 2'($urandom);
        num1  = $urandom;
        num2  = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                          input string nm);
        int lat;
        launch(o, a, b);
        check({nm, " busy_at_E0"}, busy, 1);
        wait_done(lat);
        check({nm, " latency"}, lat, exp_lat(o, b));
        check({nm, " hi"}, hi, eh);
        check({nm, " lo"}, lo, el);
        check({nm, " div_zero"}, div_zero, edz);
        m_hi = eh;
        m_lo = el;
        step();
        check({nm, " done_one_cycle"}, done, 0);
    endtask

    task automatic write_hilo(input logic [W-1:0] vh, input logic [W-1:0] vl);
        wr_hi = 1'b1; wdata = vh; step(); wr_hi = 1'b0;
        wr_lo = 1'b1; wdata = vl; step(); wr_lo = 1'b0;
        m_hi = vh;
        m_lo = vl;
    endtask

    initial begin
        int           lat, lat_b, busy_cnt, done_cnt, done_edge, dz_cnt;
        logic [W-1:0] eh, el;
        logic         edz;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd7,        32'd2,        32'd1,         32'd3};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b10, 32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        rst = 1'b1; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = '0; num1 = '0; num2 = '0; wdata = '0;
        repeat (3) step();
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;

        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);

        // MULT -3 x 5 with cycle-by-cycle busy/done observation.
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        check("mult busy_at_E0", busy, 1);
        busy_cnt = 0; done_cnt = 0; done_edge = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_edge = k; end
        end
        check("mult busy_cycles_after_E0", busy_cnt, exp_lat(2'b00, 32'd5) - 1);
        check("mult done_pulses", done_cnt, 1);
        check("mult done_edge", done_edge, exp_lat(2'b00, 32'd5));
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFF1);
        m_hi = hi === 32'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFF1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0,
                   $sformatf("vec%0d", i));

        // Divide by zero leaves MTHI/MTLO values in place.
        write_hilo(32'h11, 32'h22);
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        run_op(2'b11, 32'd1234, 32'd0, 32'h11, 32'h22, 1'b1, "divu_zero");

        // Cancel at E11 of a DIV, with an ignored start pulse at E5.
        launch(2'b10, 32'd100, 32'd7);
        done_cnt = 0; dz_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) begin start = 1'b1; op = 2'b01; num1 = 32'd3; num2 = 32'd3; end
            if (k == 6) start = 1'b0;
            if (k == 11) begin
                check("cancel busy_before", busy, 1);
                cancel = 1'b1;
            end
            step();
            if (k == 11) begin
                cancel = 1'b0;
                check("cancel busy_after_E11", busy, 0);
            end
            if (done) done_cnt++;
            if (div_zero) dz_cnt++;
        end
        check("cancel no_done", done_cnt, 0);
        check("cancel no_div_zero", dz_cnt, 0);
        check("cancel busy_end", busy, 0);
        check("cancel hi", hi, m_hi);
        check("cancel lo", lo, m_lo);

        // MTLO during CALC is visible, then overwritten at FIN; an MTHI/MTLO
        // colliding with the FIN write loses.
        launch(2'b11, 32'd9, 32'd2);
        for (int k = 1; k <= W + 1; k++) begin
            if (k == 6) begin wr_lo = 1'b1; wdata = 32'h5555; end
            if (k == 7) wr_lo = 1'b0;
            if (k == W + 1) begin wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hABCD; end
            step();
            if (k == 6) check("mtlo_in_calc lo", lo, 32'h5555);
        end
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("fin_wins done", done, 1);
        check("fin_wins hi", hi, 32'd1);
        check("fin_wins lo", lo, 32'd4);
        m_hi = 32'd1;
        m_lo = 32'd4;

        // Cancel in the FIN cycle suppresses the write and done.
        launch(2'b11, 32'd100, 32'd3);
        done_cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == W + 1) cancel = 1'b1;
            step();
            cancel = 1'b0;
            if (done) done_cnt++;
        end
        check("fin_cancel no_done", done_cnt, 0);
        check("fin_cancel hi", hi, m_hi);
        check("fin_cancel lo", lo, m_lo);
        check("fin_cancel busy", busy, 0);

        // Back-to-back: new start accepted in the done cycle.
        launch(2'b01, 32'd1000, 32'd1000);
        wait_done(lat);
        check("b2b first latency", lat, exp_lat(2'b01, 32'd1000));
        check("b2b first lo", lo, 32'd1000000);
        check("b2b first hi", hi, 32'd0);
        launch(2'b11, 32'd1000000, 32'd7);
        check("b2b second busy", busy, 1);
        wait_done(lat_b);
        check("b2b second latency", lat_b, exp_lat(2'b11, 32'd7));
        check("b2b second lo", lo, 32'd142857);
        check("b2b second hi", hi, 32'd1);
        m_hi = 32'd1;
        m_lo = 32'd142857;
        step();

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            int           sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = '0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = W'($urandom_range(1, 15));
            model(ro, ra, rb, eh, el, edz);
            run_op(ro, ra, rb, eh, el, edz, $sformatf("rand%0d op%0d", i, ro));
        end

        // Synchronous reset at E15 of a MULT, then a fresh MULT.
        write_hilo(32'hDEAD_BEEF, 32'h1234_5678);
        launch(2'b00, 32'h0001_2345, 32'h0000_0777);
        for (int k = 1; k <= 14; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midop_reset hi", hi, 0);
        check("midop_reset lo", lo, 0);
        check("midop_reset busy", busy, 0);
        check("midop_reset done", done, 0);
        check("midop_reset div_zero", div_zero, 0);
        m_hi = '0;
        m_lo = '0;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done) done_cnt++;
        end
        check("midop_reset no_late_done", done_cnt, 0);
        run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "after_reset_mult");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
